// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and helpers for the fetch PC unit and its BTB.
package fetch_pkg;

  localparam int unsigned BTB_IDX  = 6;
  localparam logic [31:0] RESET_PC = 32'h60;
  localparam int unsigned CNT_W    = 32;

  // Tag field is sized for the smallest possible index width; unused upper
  // tag bits are always zero on both write and compare.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] tgt;
  } btb_entry_t;

  typedef enum logic [1:0] {
    PC_REDIRECT,
    PC_HOLD,
    PC_PREDICT,
    PC_SEQ
  } pc_sel_e;

  // Both helpers take the word address (pc[31:2]).
  function automatic logic [29:0] btb_idx(input logic [29:0] word, input int unsigned idx_w);
    logic [29:0] mask;
    mask = '1;
    mask = ~(mask << idx_w);
    return word & mask;
  endfunction

  function automatic logic [29:0] btb_tag(input logic [29:0] word, input int unsigned idx_w);
    return word >> idx_w;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch/resolve bus between the fetch PC unit and the surrounding pipeline.
interface fetch_pc_unit_if #(parameter int unsigned CNT_W = 32);

  logic             stall;
  logic [31:0]      pc_out;
  logic [1:0]       bht_pred;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             resolve_valid;
  logic [31:0]      idex_pc_value;
  logic [31:0]      idex_target;
  logic             br_taken;
  logic             idex_pred_taken;
  logic [31:0]      idex_pred_target;
  logic             mispredict;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport slave (
    input  stall, bht_pred, resolve_valid, idex_pc_value, idex_target,
           br_taken, idex_pred_taken, idex_pred_target,
    output pc_out, pred_taken, pred_target, mispredict,
           resolved_cnt, mispred_cnt
  );

  modport master (
    output stall, bht_pred, resolve_valid, idex_pc_value, idex_target,
           br_taken, idex_pred_taken, idex_pred_target,
    input  pc_out, pred_taken, pred_target, mispredict,
           resolved_cnt, mispred_cnt
  );

endinterface

// File: rtl/fetch_pc_unit_btb_array.sv
// Direct-mapped tagged BTB: one combinational read port, one synchronous
// write port; reset clears valid bits only.
module btb_array
  import fetch_pkg::*;
#(
  parameter int unsigned BTB_IDX = fetch_pkg::BTB_IDX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_word,
  output logic        rd_hit,
  output logic [29:0] rd_tgt,
  input  logic        wr_en,
  input  logic [29:0] wr_word,
  input  logic [29:0] wr_tgt
);

  localparam int unsigned DEPTH = 1 << BTB_IDX;

  btb_entry_t         entries_q [DEPTH];
  btb_entry_t         entries_d [DEPTH];
  btb_entry_t         rd_entry;
  logic [29:0]        rd_idx_full;
  logic [29:0]        wr_idx_full;
  logic [BTB_IDX-1:0] rd_idx;
  logic [BTB_IDX-1:0] wr_idx;
  logic               unused_idx_hi;

  assign rd_idx_full   = btb_idx(rd_word, BTB_IDX);
  assign wr_idx_full   = btb_idx(wr_word, BTB_IDX);
  assign rd_idx        = rd_idx_full[BTB_IDX-1:0];
  assign wr_idx        = wr_idx_full[BTB_IDX-1:0];
  assign unused_idx_hi = ^{rd_idx_full[29:BTB_IDX], wr_idx_full[29:BTB_IDX]};

  // Read port: lookup against current contents (pre-write on a same-index write).
  always_comb begin
    rd_entry = entries_q[rd_idx];
    rd_hit   = rd_entry.valid && (rd_entry.tag == btb_tag(rd_word, BTB_IDX));
    rd_tgt   = rd_entry.tgt;
  end

  // Write port: install a taken branch's tag and target.
  always_comb begin
    entries_d = entries_q;
    if (wr_en) begin
      entries_d[wr_idx].valid = 1'b1;
      entries_d[wr_idx].tag   = btb_tag(wr_word, BTB_IDX);
      entries_d[wr_idx].tgt   = wr_tgt;
    end
  end

  // Entry storage; reset drops valid bits but leaves tags and targets.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage next-PC generator: fetch PC register, BTB-based prediction,
// EX-stage mispredict repair and resolution/mispredict perf counters.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned BTB_IDX  = fetch_pkg::BTB_IDX,
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int unsigned CNT_W    = fetch_pkg::CNT_W
) (
  input logic           clk,
  input logic           rst,
  fetch_pc_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      pred_target;
  logic             pred_taken;
  logic             btb_hit;
  logic [29:0]      btb_tgt;
  logic             btb_wr_en;
  logic             mispredict;
  pc_sel_e          pc_sel;
  logic [CNT_W-1:0] resolved_cnt_q;
  logic [CNT_W-1:0] resolved_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d;

  assign btb_wr_en = bus.resolve_valid && bus.br_taken;

  btb_array #(
    .BTB_IDX(BTB_IDX)
  ) u_btb (
    .clk     (clk),
    .rst     (rst),
    .rd_word (pc_q[31:2]),
    .rd_hit  (btb_hit),
    .rd_tgt  (btb_tgt),
    .wr_en   (btb_wr_en),
    .wr_word (bus.idex_pc_value[31:2]),
    .wr_tgt  (bus.idex_target[31:2])
  );

  // Prediction and mispredict detection.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    pred_taken  = btb_hit && bus.bht_pred[1];
    pred_target = btb_hit ? {btb_tgt, 2'b00} : pc_plus4;
    mispredict  = bus.resolve_valid &&
                  ((bus.br_taken != bus.idex_pred_taken) ||
                   (bus.br_taken && (bus.idex_pred_target != bus.idex_target)));
  end

  // Next-PC source priority: redirect beats stall beats prediction.
  always_comb begin
    pc_sel = PC_SEQ;
    if (mispredict) begin
      pc_sel = PC_REDIRECT;
    end else if (bus.stall) begin
      pc_sel = PC_HOLD;
    end else if (pred_taken) begin
      pc_sel = PC_PREDICT;
    end
  end

  // Next-PC mux.
  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      PC_REDIRECT: pc_d = bus.br_taken ? bus.idex_target : bus.idex_pc_value + 32'd4;
      PC_HOLD:     pc_d = pc_q;
      PC_PREDICT:  pc_d = pred_target;
      default:     pc_d = pc_plus4;
    endcase
  end

  // Saturating perf counters.
  always_comb begin
    resolved_cnt_d = resolved_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if (bus.resolve_valid && (resolved_cnt_q != '1)) begin
      resolved_cnt_d = resolved_cnt_q + CNT_ONE;
    end
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_ONE;
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      resolved_cnt_q <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pred_taken   = pred_taken;
  assign bus.pred_target  = pred_target;
  assign bus.mispredict   = mispredict;
  assign bus.resolved_cnt = resolved_cnt_q;
  assign bus.mispred_cnt  = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios followed by random traffic,
// all checked against a behavioural model of the fetch unit.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_pc_unit_if #(.CNT_W(32)) bus ();

  fetch_pc_unit #(
    .BTB_IDX (6),
    .RESET_PC(32'h60),
    .CNT_W   (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: fetch PC, counters, and a table of remembered taken branches.
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_res;
  logic [31:0] m_mis;
  bit          m_valid [64];
  logic [31:0] m_owner [64];
  logic [31:0] m_tgt   [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, check state.
  task automatic step(input bit r, input bit st, input logic [1:0] bht, input bit rv,
                      input logic [31:0] ipc, input logic [31:0] itgt, input bit bt,
                      input bit ipt, input logic [31:0] iptgt);
    int unsigned i;
    int unsigned j;
    bit          hit;
    bit          e_pt;
    bit          e_mp;
    logic [31:0] e_ptgt;
    logic [31:0] nxt;
    rst                  = r;
    bus.stall            = st;
    bus.bht_pred         = bht;
    bus.resolve_valid    = rv;
    bus.idex_pc_value    = ipc;
    bus.idex_target      = itgt;
    bus.br_taken         = bt;
    bus.idex_pred_taken  = ipt;
    bus.idex_pred_target = iptgt;
    #2;
    i      = (m_pc / 4) % 64;
    hit    = m_valid[i] && ((m_owner[i] / 256) == (m_pc / 256));
    e_pt   = hit && bht[1];
    e_ptgt = hit ? m_tgt[i] : m_pc + 32'd4;
    e_mp   = rv && ((bt != ipt) || (bt && (iptgt != itgt)));
    if (m_known) begin
      chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e_pt});
      chk("pred_target", bus.pred_target, e_ptgt);
      chk("mispredict", {31'd0, bus.mispredict}, {31'd0, e_mp});
    end
    if (r)         nxt = 32'h60;
    else if (e_mp) nxt = bt ? itgt : ipc + 32'd4;
    else if (st)   nxt = m_pc;
    else if (e_pt) nxt = e_ptgt;
    else           nxt = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
      m_res   = 0;
      m_mis   = 0;
      m_known = 1'b1;
    end else begin
      if (rv && bt) begin
        j          = (ipc / 4) % 64;
        m_valid[j] = 1'b1;
        m_owner[j] = ipc;
        m_tgt[j]   = itgt & ~32'h3;
      end
      if (rv && (m_res != 32'hFFFF_FFFF)) m_res = m_res + 1;
      if (e_mp && (m_mis != 32'hFFFF_FFFF)) m_mis = m_mis + 1;
    end
    m_pc = nxt;
    if (m_known) begin
      chk("pc_out", bus.pc_out, m_pc);
      chk("resolved_cnt", bus.resolved_cnt, m_res);
      chk("mispred_cnt", bus.mispred_cnt, m_mis);
    end
  endtask

  task automatic idle(input logic [1:0] bht);
    step(1'b0, 1'b0, bht, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Taken jump from an unrelated PC that the fetch side did not predict.
  task automatic jump_to(input logic [31:0] src, input logic [31:0] dst);
    step(1'b0, 1'b0, 2'b00, 1'b1, src, dst, 1'b1, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] p;
    p = 32'h80 + ($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 1) == 1) p = p + 32'h100;
    return p;
  endfunction

  initial begin
    logic [31:0] ipc;
    logic [31:0] itgt;
    logic [31:0] iptgt;

    // Reset and sequential fetch.
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("reset_pc", bus.pc_out, 32'h60);
    chk("reset_res_cnt", bus.resolved_cnt, 32'h0);
    for (int n = 0; n < 3; n++) idle(2'b11);
    chk("seq_pc", bus.pc_out, 32'h6C);

    // Unpredicted taken branch 0x80 -> 0x200.
    step(1'b0, 1'b0, 2'b00, 1'b1, 32'h80, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("redirect_pc", bus.pc_out, 32'h200);
    chk("redirect_mis_cnt", bus.mispred_cnt, 32'd1);
    jump_to(32'h300, 32'h80);
    idle(2'b10);
    chk("btb_pred_pc", bus.pc_out, 32'h200);

    // BTB hit but weak-not-taken counter; correctly predicted not-taken resolve.
    jump_to(32'h300, 32'h80);
    idle(2'b01);
    chk("hit_not_taken_pc", bus.pc_out, 32'h84);
    step(1'b0, 1'b0, 2'b00, 1'b1, 32'h80, 32'h200, 1'b0, 1'b0, 32'h0);

    // Predicted taken but actually not taken; entry must stay valid.
    jump_to(32'h300, 32'h80);
    idle(2'b11);
    step(1'b0, 1'b0, 2'b00, 1'b1, 32'h80, 32'h200, 1'b0, 1'b1, 32'h200);
    chk("nt_repair_pc", bus.pc_out, 32'h84);
    jump_to(32'h300, 32'h80);
    idle(2'b11);
    chk("entry_kept_pc", bus.pc_out, 32'h200);

    // Aliasing index with a different tag.
    jump_to(32'h340, 32'h180);
    idle(2'b11);
    chk("alias_pc", bus.pc_out, 32'h184);

    // Stall with mispredict, stall alone, reset with a resolve in flight.
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
    chk("stall_redirect_pc", bus.pc_out, 32'h80);
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("stall_hold_pc", bus.pc_out, 32'h80);
    step(1'b1, 1'b0, 2'b00, 1'b1, 32'h500, 32'h700, 1'b1, 1'b0, 32'h0);
    chk("rst_mid_redirect_pc", bus.pc_out, 32'h60);
    jump_to(32'h300, 32'h80);
    idle(2'b11);
    chk("btb_cleared_pc", bus.pc_out, 32'h84);
    jump_to(32'h340, 32'h500);
    idle(2'b11);
    chk("no_write_in_rst_pc", bus.pc_out, 32'h504);

    // PC wraps modulo 2^32.
    jump_to(32'h300, 32'hFFFF_FFF8);
    idle(2'b00);
    idle(2'b00);
    chk("wrap_pc", bus.pc_out, 32'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      ipc   = pool_pc();
      itgt  = pool_pc();
      iptgt = ($urandom_range(0, 1) == 1) ? itgt : pool_pc();
      step(($urandom_range(0, 127) == 0),
           ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1),
           ipc, itgt,
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           iptgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
